// File: rtl/instruction_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_sequencer
// Description : Moore FSM that fetches instructions from memory, pulses the
//               instruction latch enable and presents the captured word to
//               the decoder. Branch redirection and a memory-timeout fault
//               are also handled here.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_run,
    input  logic                  i_branch_valid,
    input  logic [ADDR_WIDTH-1:0] i_branch_addr,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  o_latch_enable,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_fault
);

    // Counter is wide enough to hold TIMEOUT itself.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Value of the wait counter on the last FETCH cycle allowed without ack.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_VALID = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [CNT_W-1:0]      r_cnt;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [DATA_WIDTH-1:0] w_instr_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;

    // State, PC, instruction and wait-counter registers with async reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_instr <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; a branch outside FAULT overrides ack and ready.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_branch_valid) begin
                    w_pc_nxt = i_branch_addr;
                end
                if (i_run) begin
                    w_state_nxt = S_FETCH;
                    w_cnt_nxt   = '0;
                end
            end
            S_FETCH: begin
                if (i_branch_valid) begin
                    // Any same-cycle read data belongs to the old address.
                    w_pc_nxt  = i_branch_addr;
                    w_cnt_nxt = '0;
                end else if (i_mem_ack) begin
                    w_instr_nxt = i_mem_data;
                    w_pc_nxt    = r_pc + ADDR_WIDTH'(1);
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_LATCH;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_FAULT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_LATCH: begin
                if (i_branch_valid) begin
                    w_pc_nxt    = i_branch_addr;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (i_branch_valid) begin
                    w_pc_nxt    = i_branch_addr;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FETCH;
                end else if (i_instr_ready) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = i_run ? S_FETCH : S_IDLE;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from registered state.
    assign o_mem_req      = (r_state == S_FETCH);
    assign o_mem_addr     = r_pc;
    assign o_latch_enable = (r_state == S_LATCH);
    assign o_instr        = r_instr;
    assign o_instr_valid  = (r_state == S_VALID);
    assign o_pc           = r_pc;
    assign o_fault        = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_sequencer
// Description : Directed bench for instruction_fetch_sequencer with an
//               expected-instruction queue filled when memory returns data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_sequencer;

    logic       i_clk;
    logic       i_reset;
    logic       i_run;
    logic       i_branch_valid;
    logic [7:0] i_branch_addr;
    logic       o_mem_req;
    logic [7:0] o_mem_addr;
    logic       i_mem_ack;
    logic [7:0] i_mem_data;
    logic       o_latch_enable;
    logic [7:0] o_instr;
    logic       o_instr_valid;
    logic       i_instr_ready;
    logic [7:0] o_pc;
    logic       o_fault;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb[$];

    instruction_fetch_sequencer #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8),
        .TIMEOUT   (15)
    ) u_dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_run         (i_run),
        .i_branch_valid(i_branch_valid),
        .i_branch_addr (i_branch_addr),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_ack     (i_mem_ack),
        .i_mem_data    (i_mem_data),
        .o_latch_enable(o_latch_enable),
        .o_instr       (o_instr),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .o_pc          (o_pc),
        .o_fault       (o_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the decoder-side word against the oldest expected instruction.
    task automatic check_front(input string tag);
        logic [7:0] e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb[0];
            check(tag, {24'd0, o_instr}, {24'd0, e});
        end
    endtask

    task automatic accept_pop(input string tag);
        logic [7:0] e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check(tag, {24'd0, o_instr}, {24'd0, e});
        end
    endtask

    initial begin
        i_reset = 1'b1; i_run = 1'b0; i_branch_valid = 1'b0; i_branch_addr = 8'h00;
        i_mem_ack = 1'b0; i_mem_data = 8'h00; i_instr_ready = 1'b0;
        tick(); tick();

        // Reset values
        check("rst_mem_req", 32'(o_mem_req), 32'd0);
        check("rst_pc", 32'(o_pc), 32'h00);
        check("rst_instr", 32'(o_instr), 32'h00);
        check("rst_valid", 32'(o_instr_valid), 32'd0);
        check("rst_latch", 32'(o_latch_enable), 32'd0);
        check("rst_fault", 32'(o_fault), 32'd0);
        i_reset = 1'b0;
        tick();
        check("idle_mem_req", 32'(o_mem_req), 32'd0);

        // Basic fetch: ack on second FETCH cycle with 0xA5
        i_run = 1'b1;
        tick();
        check("f1_mem_req", 32'(o_mem_req), 32'd1);
        check("f1_addr", 32'(o_mem_addr), 32'h00);
        tick();
        check("f2_mem_req", 32'(o_mem_req), 32'd1);
        check("f2_addr", 32'(o_mem_addr), 32'h00);
        i_mem_ack = 1'b1; i_mem_data = 8'hA5; sb.push_back(8'hA5);
        tick();
        i_mem_ack = 1'b0; i_mem_data = 8'h00;
        check("l_latch", 32'(o_latch_enable), 32'd1);
        check("l_mem_req", 32'(o_mem_req), 32'd0);
        check("l_pc", 32'(o_pc), 32'h01);
        check_front("l_instr");
        tick();
        check("v_latch", 32'(o_latch_enable), 32'd0);
        check("v_valid", 32'(o_instr_valid), 32'd1);
        check_front("v_instr");

        // Backpressure for 5 cycles
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", 32'(o_instr_valid), 32'd1);
            check("bp_mem_req", 32'(o_mem_req), 32'd0);
            check_front("bp_instr");
        end
        i_instr_ready = 1'b1;
        accept_pop("bp_accept");
        tick();
        i_instr_ready = 1'b0;
        check("bp_next_req", 32'(o_mem_req), 32'd1);
        check("bp_next_addr", 32'(o_mem_addr), 32'h01);
        check("bp_next_valid", 32'(o_instr_valid), 32'd0);

        // PC wrap: branch to 0xFF then capture
        i_branch_valid = 1'b1; i_branch_addr = 8'hFF;
        tick();
        i_branch_valid = 1'b0;
        check("wr_addr", 32'(o_mem_addr), 32'hFF);
        check("wr_req", 32'(o_mem_req), 32'd1);
        i_mem_ack = 1'b1; i_mem_data = 8'h5A; sb.push_back(8'h5A);
        tick();
        i_mem_ack = 1'b0;
        check("wr_pc", 32'(o_pc), 32'h00);
        check("wr_latch", 32'(o_latch_enable), 32'd1);
        check_front("wr_instr");
        i_instr_ready = 1'b1;
        tick();
        check("wr_valid", 32'(o_instr_valid), 32'd1);
        accept_pop("wr_accept");
        tick();
        i_instr_ready = 1'b0;
        check("wr_next_addr", 32'(o_mem_addr), 32'h00);

        // Branch/ack collision: 0x3C must never be captured
        i_mem_ack = 1'b1; i_mem_data = 8'h3C;
        i_branch_valid = 1'b1; i_branch_addr = 8'h40;
        tick();
        i_mem_ack = 1'b0; i_branch_valid = 1'b0;
        check("co_latch", 32'(o_latch_enable), 32'd0);
        check("co_req", 32'(o_mem_req), 32'd1);
        check("co_addr", 32'(o_mem_addr), 32'h40);
        check("co_instr", 32'(o_instr), 32'h5A);
        i_mem_ack = 1'b1; i_mem_data = 8'h77; sb.push_back(8'h77);
        tick();
        i_mem_ack = 1'b0;
        check("co2_latch", 32'(o_latch_enable), 32'd1);
        check("co2_pc", 32'(o_pc), 32'h41);
        check_front("co2_instr");
        // Dropping run mid-flight still completes this instruction
        i_run = 1'b0;
        tick();
        check("co2_valid", 32'(o_instr_valid), 32'd1);
        i_instr_ready = 1'b1;
        accept_pop("co2_accept");
        tick();
        i_instr_ready = 1'b0;
        check("stop_req", 32'(o_mem_req), 32'd0);
        check("stop_valid", 32'(o_instr_valid), 32'd0);
        tick();
        check("stop_req2", 32'(o_mem_req), 32'd0);

        // Timeout: 15 FETCH cycles without ack, then sticky FAULT
        i_run = 1'b1;
        tick();
        check("to_addr", 32'(o_mem_addr), 32'h41);
        check("to_req_1", 32'(o_mem_req), 32'd1);
        for (int k = 2; k <= 15; k++) begin
            tick();
            check("to_req_n", 32'(o_mem_req), 32'd1);
            check("to_fault_n", 32'(o_fault), 32'd0);
        end
        tick();
        check("to_fault", 32'(o_fault), 32'd1);
        check("to_req_off", 32'(o_mem_req), 32'd0);
        i_branch_valid = 1'b1; i_branch_addr = 8'h10;
        tick();
        i_branch_valid = 1'b0;
        tick(); tick();
        check("to_sticky", 32'(o_fault), 32'd1);
        check("to_pc_held", 32'(o_pc), 32'h41);
        check("to_req_held", 32'(o_mem_req), 32'd0);
        i_reset = 1'b1;
        #1;
        check("to_rst_fault", 32'(o_fault), 32'd0);
        check("to_rst_pc", 32'(o_pc), 32'h00);
        tick();
        i_reset = 1'b0;
        i_run = 1'b0;
        tick();
        check("to_idle_req", 32'(o_mem_req), 32'd0);

        // Asynchronous reset between edges while in FETCH with ack pending
        i_run = 1'b1;
        tick();
        check("ar_req", 32'(o_mem_req), 32'd1);
        i_mem_ack = 1'b1; i_mem_data = 8'h99;
        #3;
        i_reset = 1'b1;
        #1;
        check("ar_req_off", 32'(o_mem_req), 32'd0);
        check("ar_pc", 32'(o_pc), 32'h00);
        check("ar_valid", 32'(o_instr_valid), 32'd0);
        tick();
        check("ar_latch", 32'(o_latch_enable), 32'd0);
        check("ar_instr", 32'(o_instr), 32'h00);
        i_mem_ack = 1'b0;
        i_reset = 1'b0;
        tick();
        check("ar_first_req", 32'(o_mem_req), 32'd1);
        check("ar_first_addr", 32'(o_mem_addr), 32'h00);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
